// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   uart_state_e   : transmitter FSM states
//   UART_DATA_BITS : data bits per frame (8N1)
//   calc_div       : clock cycles per bit, truncated
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write port and status/line outputs of the buffered UART transmitter.
//   wr, data      : producer -> transmitter write strobe and byte
//   full, empty   : FIFO occupancy flags
//   busy, overrun : frame in flight, sticky dropped-write flag
//   txd           : serial line
interface uart_tx_fifo_if import uart_pkg::*; ();
    logic                      wr;
    logic [UART_DATA_BITS-1:0] data;
    logic                      full;
    logic                      empty;
    logic                      busy;
    logic                      overrun;
    logic                      txd;

    modport master (
        output wr, data,
        input  full, empty, busy, overrun, txd
    );

    modport slave (
        input  wr, data,
        output full, empty, busy, overrun, txd
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
//   clk, reset : clock, async active-high reset
//   i_wr       : push i_wdata (ignored while o_full)
//   i_rd       : pop head (ignored while o_empty)
//   o_rdata    : current head, valid while !o_empty
//   o_full/o_empty/o_count : occupancy, all registered
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_rd,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // Flags are registered, so a write while full is refused even when a
    // pop frees a slot in the same cycle.
    assign w_push = i_wr && !r_full;
    assign w_pop  = i_rd && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (DEPTH_LOG2+1)'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - (DEPTH_LOG2+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // Pointers wrap naturally: depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes written through the bus port are
// queued in a FIFO and shifted out LSB first at CLK_HZ/BAUD cycles per bit.
//   clk, reset : clock, async active-high reset (line goes high at once)
//   bus        : slave side of uart_tx_fifo_if (wr/data in; full, empty,
//                busy, overrun, txd out -- all registered)
module uart_tx_fifo import uart_pkg::*; #(
    parameter int CLK_HZ     = 24000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

    uart_state_e               r_state;
    logic [CW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_txd;
    logic                      r_busy;
    logic                      r_overrun;

    logic [UART_DATA_BITS-1:0] w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_bit_end;
    logic [DEPTH_LOG2:0]       w_unused_count;  // occupancy not needed here

    assign w_bit_end = (r_cnt == LAST_CNT);

    // A byte leaves the FIFO only when the shifter takes it: from idle, or
    // on the last stop cycle so the next frame follows with no gap.
    assign w_pop = !w_empty &&
                   ((r_state == IDLE) || (r_state == STOP && w_bit_end));

    sync_fifo #(
        .WIDTH      (UART_DATA_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (bus.wr),
        .i_wdata (bus.data),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_unused_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_overrun <= 1'b0;
        else if (bus.wr && w_full)
            r_overrun <= 1'b1;
    end

    // txd is registered: each transition also loads the level of the
    // bit being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_cnt   <= '0;
                        r_state <= START;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= DATA;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == LAST_BIT) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + IW'(1);
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.txd     = r_txd;
    assign bus.busy    = r_busy;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;
    assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at default parameters (DIV = 208, 16-entry FIFO).
// A frame-level model (byte queue + position within the current 10-bit
// frame) predicts every output each cycle; a line decoder recovers the
// transmitted bytes for hand-computed literal checks.
module tb_uart_tx_fifo;
    localparam int DIV   = 208;
    localparam int FRAME = 10 * DIV;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_fifo_if bus_if ();

    uart_tx_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [7:0] q[$];
    logic [7:0] cur    = '0;
    int         ft     = 0;
    logic       m_busy = 1'b0, m_full = 1'b0, m_empty = 1'b1;
    logic       m_txd  = 1'b1, m_ovr  = 1'b0;
    logic       acc, fend, start;

    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            cur = '0; ft = 0;
            m_busy = 0; m_full = 0; m_empty = 1; m_txd = 1; m_ovr = 0;
        end else begin
            acc = bus_if.wr && !m_full;
            if (bus_if.wr && m_full) m_ovr = 1;
            fend  = m_busy && (ft == FRAME - 1);
            start = (!m_busy || fend) && !m_empty;
            if (start) begin
                cur = q.pop_front(); ft = 0; m_busy = 1;
            end else if (fend) begin
                m_busy = 0; ft = 0;
            end else if (m_busy) begin
                ft++;
            end
            if (acc) q.push_back(bus_if.data);
            m_empty = (q.size() == 0);
            m_full  = (q.size() == DEPTH);
            m_txd   = m_busy ? frame_bit(cur, ft / DIV) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("txd",     bus_if.txd,     m_txd);
            check("busy",    bus_if.busy,    m_busy);
            check("empty",   bus_if.empty,   m_empty);
            check("full",    bus_if.full,    m_full);
            check("overrun", bus_if.overrun, m_ovr);
        end
    end

    // ---------------- line decoder and busy counter ----------------
    logic [7:0] rxq[$];
    logic       rx_on = 0, prev_txd = 1;
    int         rx_t  = 0;
    logic [7:0] rx_b  = '0;
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (bus_if.busy) busy_cnt++;
        if (reset) begin
            rx_on = 0; prev_txd = 1;
        end else begin
            if (!rx_on) begin
                if (prev_txd && !bus_if.txd) begin
                    rx_on = 1; rx_t = 0;
                end
            end else begin
                rx_t++;
                if (rx_t % DIV == DIV / 2) begin
                    if (rx_t / DIV >= 1 && rx_t / DIV <= 8)
                        rx_b[rx_t/DIV - 1] = bus_if.txd;
                    else if (rx_t / DIV == 9) begin
                        check("stop_bit", bus_if.txd, 1'b1);
                        rxq.push_back(rx_b);
                        rx_on = 0;
                    end
                end
            end
            prev_txd = bus_if.txd;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_byte(input logic [7:0] b);
        bus_if.wr = 1'b1; bus_if.data = b;
        @(posedge clk); #1;
        bus_if.wr = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (busy_cnt > 0 && !bus_if.busy) done = 1;
        end
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL wait_idle: busy still high after %0d cycles", limit);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1; reset = 1'b1;
        repeat (3) @(posedge clk); #1; reset = 1'b0;
    endtask

    logic [7:0] exp3 [3] = '{8'h55, 8'hAA, 8'h0F};

    initial begin
        bus_if.wr = 1'b0; bus_if.data = '0;
        // reset state
        repeat (2) @(negedge clk);
        check("rst_txd", bus_if.txd, 1); check("rst_busy", bus_if.busy, 0);
        check("rst_empty", bus_if.empty, 1); check("rst_full", bus_if.full, 0);
        check("rst_overrun", bus_if.overrun, 0);
        @(posedge clk); #1; reset = 1'b0;

        // idle, no writes
        repeat (5000) @(posedge clk); #1;
        check("idle_txd", bus_if.txd, 1); check("idle_busy", bus_if.busy, 0);
        check("idle_empty", bus_if.empty, 1);

        // single byte 0x41
        busy_cnt = 0;
        wr_byte(8'h41);
        @(negedge clk);
        check("w1_empty_fall", bus_if.empty, 0); check("w1_txd_still_high", bus_if.txd, 1);
        @(negedge clk);
        check("w1_txd_fall", bus_if.txd, 0); check("w1_busy_rise", bus_if.busy, 1);
        check("w1_empty_rise", bus_if.empty, 1);
        repeat (207) @(negedge clk);
        check("w1_start_last", bus_if.txd, 0);
        @(negedge clk);
        check("w1_bit0", bus_if.txd, 1);
        @(posedge clk); #1;
        wait_idle(3000);
        check("w1_busy_cycles", busy_cnt, 2080);
        check("w1_rx_count", rxq.size(), 1);
        if (rxq.size() > 0) check("w1_rx_byte", rxq[0], 8'h41);
        rxq.delete();

        // three back-to-back frames
        busy_cnt = 0;
        wr_byte(8'h55); wr_byte(8'hAA); wr_byte(8'h0F);
        wait_idle(8000);
        check("b2b_busy_cycles", busy_cnt, 6240);
        check("b2b_rx_count", rxq.size(), 3);
        for (int i = 0; i < 3 && i < rxq.size(); i++) check("b2b_rx_byte", rxq[i], exp3[i]);
        rxq.delete();

        // 17 writes fill the FIFO, 18th is dropped
        busy_cnt = 0;
        for (int i = 0; i < 17; i++) wr_byte(8'h10 + 8'(i));
        @(negedge clk);
        check("fill_full", bus_if.full, 1); check("fill_no_ovr", bus_if.overrun, 0);
        @(posedge clk); #1;
        wr_byte(8'hEE);
        @(negedge clk);
        check("fill_overrun", bus_if.overrun, 1); check("fill_still_full", bus_if.full, 1);
        @(posedge clk); #1;
        wait_idle(40000);
        check("fill_busy_cycles", busy_cnt, 17 * 2080);
        check("fill_rx_count", rxq.size(), 17);
        for (int i = 0; i < 17 && i < rxq.size(); i++) check("fill_rx_byte", rxq[i], 8'h10 + 8'(i));
        check("fill_overrun_sticky", bus_if.overrun, 1);
        do_reset();
        check("post_rst_overrun", bus_if.overrun, 0);
        rxq.delete();

        // reset mid-DATA with 3 bytes queued
        for (int i = 0; i < 4; i++) wr_byte(8'hC0 + 8'(i));
        repeat (3 * DIV) @(posedge clk); #1;
        check("mid_in_frame_busy", bus_if.busy, 1);
        reset = 1'b1; #1;
        check("mid_rst_txd", bus_if.txd, 1); check("mid_rst_busy", bus_if.busy, 0);
        check("mid_rst_empty", bus_if.empty, 1); check("mid_rst_full", bus_if.full, 0);
        repeat (3) @(posedge clk); #1; reset = 1'b0;
        repeat (3000) @(posedge clk); #1;
        check("mid_quiet_txd", bus_if.txd, 1); check("mid_quiet_busy", bus_if.busy, 0);
        check("mid_rx_none", rxq.size(), 0);

        // write while full on the STOP->START pop cycle (edge n+2081)
        for (int i = 0; i < 17; i++) wr_byte(8'h20 + 8'(i));
        repeat (2064) @(posedge clk); #1;
        check("pop_pre_full", bus_if.full, 1); check("pop_pre_ovr", bus_if.overrun, 0);
        wr_byte(8'hEE);
        @(negedge clk);
        check("pop_full_drop", bus_if.full, 0); check("pop_overrun", bus_if.overrun, 1);
        @(posedge clk); #1;
        wr_byte(8'h77);
        @(negedge clk);
        check("pop_count15_plus1", bus_if.full, 1);
        repeat (100) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
